// File: rtl/iomem_arbiter.sv
// Round-robin arbiter sharing the iomem peripheral bus between the CPU (m0) and DMA (m1),
// with a per-transfer watchdog that completes a hung access with ERR_DATA.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    output logic        s_owner,
    output logic        timeout_pulse,
    output logic [7:0]  err_count,
    output logic [1:0]  dbg_state
);

    // Handshake: a master holds mN_valid and its request fields until it sees mN_ready,
    // a one-cycle completion pulse; s_valid and s_* stay stable until s_ready or timeout.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_d;
    logic        last_grant, last_grant_d;
    logic [15:0] wdog, wdog_d;
    logic        s_valid_d, s_owner_d;
    logic [3:0]  s_wstrb_d;
    logic [31:0] s_addr_d, s_wdata_d;
    logic        m0_ready_d, m1_ready_d;
    logic [31:0] m0_rdata_d, m1_rdata_d;
    logic        timeout_pulse_d;
    logic [7:0]  err_count_d;
    logic        winner;

    assign dbg_state = state;

    always_comb begin
        state_d         = state;
        last_grant_d    = last_grant;
        wdog_d          = wdog;
        s_valid_d       = s_valid;
        s_owner_d       = s_owner;
        s_wstrb_d       = s_wstrb;
        s_addr_d        = s_addr;
        s_wdata_d       = s_wdata;
        m0_rdata_d      = m0_rdata;
        m1_rdata_d      = m1_rdata;
        err_count_d     = err_count;
        m0_ready_d      = 1'b0;
        m1_ready_d      = 1'b0;
        timeout_pulse_d = 1'b0;
        // On a tie the master that did not win last time takes the bus.
        winner          = (m0_valid && m1_valid) ? ~last_grant : m1_valid;

        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_d   = BUSY;
                    s_valid_d = 1'b1;
                    s_owner_d = winner;
                    s_addr_d  = winner ? m1_addr  : m0_addr;
                    s_wdata_d = winner ? m1_wdata : m0_wdata;
                    s_wstrb_d = winner ? m1_wstrb : m0_wstrb;
                    wdog_d    = 16'd0;
                end
            end
            BUSY: begin
                wdog_d = wdog + 16'd1;
                if (s_ready) begin
                    if (s_owner) begin
                        m1_rdata_d = s_rdata;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = s_rdata;
                        m0_ready_d = 1'b1;
                    end
                    s_valid_d    = 1'b0;
                    last_grant_d = s_owner;
                    state_d      = DONE;
                end else if (wdog == WDOG_LAST) begin
                    if (s_owner) begin
                        m1_rdata_d = ERR_DATA;
                        m1_ready_d = 1'b1;
                    end else begin
                        m0_rdata_d = ERR_DATA;
                        m0_ready_d = 1'b1;
                    end
                    timeout_pulse_d = 1'b1;
                    if (err_count != 8'hFF) begin
                        err_count_d = err_count + 8'd1;
                    end
                    s_valid_d    = 1'b0;
                    last_grant_d = s_owner;
                    state_d      = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            wdog          <= 16'd0;
            s_valid       <= 1'b0;
            s_owner       <= 1'b0;
            s_wstrb       <= 4'd0;
            s_addr        <= 32'd0;
            s_wdata       <= 32'd0;
            m0_ready      <= 1'b0;
            m1_ready      <= 1'b0;
            m0_rdata      <= 32'd0;
            m1_rdata      <= 32'd0;
            timeout_pulse <= 1'b0;
            err_count     <= 8'd0;
        end else begin
            state         <= state_d;
            last_grant    <= last_grant_d;
            wdog          <= wdog_d;
            s_valid       <= s_valid_d;
            s_owner       <= s_owner_d;
            s_wstrb       <= s_wstrb_d;
            s_addr        <= s_addr_d;
            s_wdata       <= s_wdata_d;
            m0_ready      <= m0_ready_d;
            m1_ready      <= m1_ready_d;
            m0_rdata      <= m0_rdata_d;
            m1_rdata      <= m1_rdata_d;
            timeout_pulse <= timeout_pulse_d;
            err_count     <= err_count_d;
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench for iomem_arbiter: a table of single-master transfers plus hand-written
// contention, reset-mid-transfer and error-counter saturation sequences.
module tb_iomem_arbiter;

    localparam int unsigned TIMEOUT = 8;
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m0_ready;
    logic [3:0]  m0_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_valid, m1_ready;
    logic [3:0]  m1_wstrb;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready, s_owner;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic        timeout_pulse;
    logic [7:0]  err_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_rd[2];

    iomem_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .s_owner(s_owner), .timeout_pulse(timeout_pulse),
        .err_count(err_count), .dbg_state(dbg_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    typedef struct {
        logic        mi;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [31:0] rdata;
        logic [31:0] exp_rdata;
        logic        exp_to;
        int          exp_cycles;
        logic [7:0]  exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input logic which);
        return which ? m1_ready : m0_ready;
    endfunction

    function automatic logic [31:0] rdv(input logic which);
        return which ? m1_rdata : m0_rdata;
    endfunction

    task automatic drive_master(input logic mi, input logic v, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb);
        if (mi) begin
            m1_valid = v; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
        end else begin
            m0_valid = v; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
        end
    endtask

    // One transfer from a single master; peripheral answers on BUSY cycle index lat.
    task automatic run_txn(input logic mi, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int lat, input logic [31:0] rdata,
                           input logic [31:0] exp_rdata, input logic exp_to,
                           input int exp_cycles, input logic [7:0] exp_err);
        int  idx;
        int  cyc;
        bit  got;
        bit  stable_bad;
        bit  oth_bad;
        logic oth;
        oth = ~mi;
        drive_master(mi, 1'b1, addr, wdata, wstrb);
        s_ready = 1'b0;
        @(negedge clk);
        check("grant_latency", {31'd0, s_valid}, 32'd1);
        check("grant_owner", {31'd0, s_owner}, {31'd0, mi});
        check("fwd_addr", s_addr, addr);
        check("fwd_wdata", s_wdata, wdata);
        check("fwd_wstrb", {28'd0, s_wstrb}, {28'd0, wstrb});
        idx = 0; cyc = 0; got = 0; stable_bad = 0; oth_bad = 0;
        while (!got && idx < 200) begin
            if (rdy(mi)) begin
                got = 1;
            end else begin
                if (s_valid) begin
                    cyc++;
                    if (s_addr !== addr || s_wdata !== wdata || s_wstrb !== wstrb || s_owner !== mi)
                        stable_bad = 1;
                end
                if (rdy(oth)) oth_bad = 1;
                s_ready = (idx == lat);
                s_rdata = (idx == lat) ? rdata : ~rdata;
                @(negedge clk);
                idx++;
            end
        end
        check("txn_complete", {31'd0, got}, 32'd1);
        drive_master(mi, 1'b0, addr, wdata, wstrb);
        s_ready = 1'b0;
        check("hold_stable", {31'd0, stable_bad}, 32'd0);
        check("valid_cycles", cyc, exp_cycles);
        check("owner_rdata", rdv(mi), exp_rdata);
        check("timeout_pulse", {31'd0, timeout_pulse}, {31'd0, exp_to});
        check("err_count", {24'd0, err_count}, {24'd0, exp_err});
        check("s_valid_done", {31'd0, s_valid}, 32'd0);
        check("other_ready", {31'd0, oth_bad | rdy(oth)}, 32'd0);
        check("other_rdata_hold", rdv(oth), last_rd[oth]);
        last_rd[mi] = exp_rdata;
        @(negedge clk);
        check("ready_one_cycle", {31'd0, rdy(mi)}, 32'd0);
        check("pulse_one_cycle", {31'd0, timeout_pulse}, 32'd0);
        check("back_to_idle", {30'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
        last_rd[0] = 32'd0; last_rd[1] = 32'd0;

        //          mi    addr          wdata         wstrb    lat  rdata         exp_rdata     to  cyc err
        vecs[0] = '{1'b0, 32'h0300_0000, 32'h0000_0000, 4'h0,   2,  32'h0000_00A5, 32'h0000_00A5, 0, 3, 8'd0};
        vecs[1] = '{1'b1, 32'h0600_0000, 32'h1234_5678, 4'hF, 255,  32'h0000_0000, ERR,           1, 8, 8'd1};
        vecs[2] = '{1'b1, 32'h0400_0010, 32'h0000_0000, 4'h0,   0,  32'h5A5A_0001, 32'h5A5A_0001, 0, 1, 8'd1};
        vecs[3] = '{1'b0, 32'h0500_0004, 32'hCAFE_F00D, 4'h3,   7,  32'h0000_1111, 32'h0000_1111, 0, 8, 8'd1};
        vecs[4] = '{1'b0, 32'h0300_0008, 32'h0000_0000, 4'h0,   6,  32'h7777_0000, 32'h7777_0000, 0, 7, 8'd1};
        vecs[5] = '{1'b1, 32'h0600_0004, 32'h0000_0000, 4'h0,   8,  32'h4444_4444, ERR,           1, 8, 8'd2};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_s_valid", {31'd0, s_valid}, 32'd0);
        check("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
        check("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
        check("rst_timeout_pulse", {31'd0, timeout_pulse}, 32'd0);
        check("rst_s_addr", s_addr, 32'd0);
        check("rst_s_wdata", s_wdata, 32'd0);
        check("rst_s_wstrb", {28'd0, s_wstrb}, 32'd0);
        check("rst_m0_rdata", m0_rdata, 32'd0);
        check("rst_m1_rdata", m1_rdata, 32'd0);
        check("rst_s_owner", {31'd0, s_owner}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].mi, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, vecs[i].lat,
                    vecs[i].rdata, vecs[i].exp_rdata, vecs[i].exp_to, vecs[i].exp_cycles,
                    vecs[i].exp_err);
        end

        // Contention, zero-wait peripheral: m0 first (m1 won last), then strict alternation.
        m0_valid = 1; m0_addr = 32'h0300_0100; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 1; m1_addr = 32'h0600_0100; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 1; s_rdata = 32'h0000_1000;
        for (int t = 1; t <= 11; t++) begin
            @(negedge clk);
            check("cont_m0_ready", {31'd0, m0_ready}, {31'd0, (t == 2 || t == 8)});
            check("cont_m1_ready", {31'd0, m1_ready}, {31'd0, (t == 5 || t == 11)});
            if (t == 2 || t == 8) begin
                check("cont_owner", {31'd0, s_owner}, 32'd0);
                check("cont_m0_rdata", m0_rdata, 32'h0000_1000 + 32'(t - 1));
            end
            if (t == 5 || t == 11) begin
                check("cont_owner", {31'd0, s_owner}, 32'd1);
                check("cont_m1_rdata", m1_rdata, 32'h0000_1000 + 32'(t - 1));
            end
            s_rdata = 32'h0000_1000 + 32'(t);
            if (t == 11) begin
                m0_valid = 0; m1_valid = 0; s_ready = 0;
            end
        end
        @(negedge clk);
        last_rd[0] = 32'h0000_1007;
        last_rd[1] = 32'h0000_100A;

        // Reset in the middle of an m1 transfer, then a tie must go to m0.
        drive_master(1'b1, 1'b1, 32'h0600_0000, 32'h0, 4'h0);
        s_ready = 0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", {30'd0, dbg_state}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_s_valid", {31'd0, s_valid}, 32'd0);
        check("midrst_state", {30'd0, dbg_state}, 32'd0);
        check("midrst_err_count", {24'd0, err_count}, 32'd0);
        check("midrst_m1_ready", {31'd0, m1_ready}, 32'd0);
        check("midrst_m1_rdata", m1_rdata, 32'd0);
        reset = 1'b0;
        drive_master(1'b0, 1'b1, 32'h0300_0020, 32'h0, 4'h0);
        @(negedge clk);
        check("tie_after_rst_valid", {31'd0, s_valid}, 32'd1);
        check("tie_after_rst_owner", {31'd0, s_owner}, 32'd0);
        check("tie_after_rst_addr", s_addr, 32'h0300_0020);
        s_ready = 1; s_rdata = 32'h0BAD_0000;
        @(negedge clk);
        check("tie_m0_ready", {31'd0, m0_ready}, 32'd1);
        check("tie_m0_rdata", m0_rdata, 32'h0BAD_0000);
        check("tie_m1_ready", {31'd0, m1_ready}, 32'd0);
        m0_valid = 0; m1_valid = 0; s_ready = 0;
        @(negedge clk);
        last_rd[0] = 32'h0BAD_0000;
        last_rd[1] = 32'd0;

        // 260 timeouts: the counter saturates at 255 while the pulse keeps firing.
        for (int i = 0; i < 260; i++) begin
            run_txn(1'b0, 32'h0700_0000 + 32'(i * 4), 32'h0, 4'h0, 1000, 32'h0, ERR, 1'b1,
                    TIMEOUT, (i >= 254) ? 8'd255 : 8'(i + 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
- Shares the single iomem peripheral bus (gpio/audio/video decode space) between two masters: m0 = CPU iomem port, m1 = DMA/blitter engine.
- Arbitrates round-robin and registers the forwarded request.
- Holds the grant until the addressed peripheral signals ready, or until a watchdog timeout fires; on timeout it completes the transfer with an error word.
- Sits between the masters and the existing address decode / ready-OR / rdata-mux logic.

Parameters:
TIMEOUT, 64, cycles s_valid may remain unanswered before forced error completion (2..65535)
ERR_DATA, 32'hDEAD_BEEF, rdata returned to the master on timeout

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
m0_valid  input  1  master 0 request; held high until m0_ready
m0_ready  output  1  master 0 completion pulse, one cycle
m0_wstrb  input  4  master 0 byte strobes (0 = read)
m0_addr  input  32  master 0 address
m0_wdata  input  32  master 0 write data
m0_rdata  output  32  master 0 read data, valid while m0_ready
m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata  as m0, for master 1
s_valid  output  1  request to peripheral bus
s_ready  input  1  OR of peripheral readies
s_wstrb  output  4  forwarded strobes
s_addr  output  32  forwarded address
s_wdata  output  32  forwarded write data
s_rdata  input  32  muxed peripheral read data
s_owner  output  1  index of current grant holder (valid while s_valid)
timeout_pulse  output  1  one-cycle pulse on each timeout completion
err_count  output  8  saturating count of timeouts

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset; it applies at any state, including mid-transaction.
- Reset values: state=IDLE; s_valid, m0_ready, m1_ready, timeout_pulse = 0; s_addr, s_wdata, s_wstrb, m0_rdata, m1_rdata = 0; s_owner=0; err_count=0; last_grant=1, so m0 wins the first tie.
- FSM states: IDLE, BUSY, DONE.
- IDLE, grant selection:
  - Only m0_valid: grant 0.
  - Only m1_valid: grant 1.
  - Both: grant !last_grant.
  - On grant, register the winner's addr/wdata/wstrb into the s_* outputs, set s_valid=1, s_owner=winner, wdog=0, and go to BUSY.
  - Arbitration latency is one cycle: s_valid rises the cycle after the master's valid is sampled.
- BUSY:
  - s_valid and all s_* outputs are held stable; wdog increments each cycle.
  - If s_ready=1: latch s_rdata into the owner's m_rdata, set the owner's m_ready=1 next cycle, s_valid=0, last_grant=s_owner, and go to DONE.
  - Else if wdog==TIMEOUT-1: owner's m_rdata=ERR_DATA, owner's m_ready=1, timeout_pulse=1, err_count+=1 (saturates at 255), s_valid=0, last_grant=s_owner, and go to DONE.
  - If s_ready and the timeout coincide in the same cycle, s_ready wins: no error and no count.
- DONE:
  - m_ready and timeout_pulse are high for exactly this one cycle, then cleared.
  - Return to IDLE next cycle. The master deasserts valid on the edge at which it sees ready, so no stale re-grant occurs.
  - Requests are not evaluated in DONE.
- Back-to-back timing: minimum transaction is 3 cycles (IDLE->BUSY->DONE) with a zero-wait-state peripheral. Under continuous contention the masters alternate strictly.
- Non-owner master: its m_ready stays 0 and its m_rdata holds its last value.
- Protocol violations: if the owner drops valid during BUSY, it is ignored; the transfer completes normally and m_ready still pulses.
- Widths: wdog is 16 bits. No arithmetic is applied to address or data; they pass through unmodified.

Test Plan:
1. Single read: m0_valid, addr=0x0300_0000, wstrb=0; peripheral asserts s_ready 2 cycles after s_valid with rdata=0x0000_00A5 -> s_valid rises 1 cycle after request; m0_ready pulses one cycle with m0_rdata=0xA5; m1_ready stays 0.
2. Contention: m0 and m1 both valid continuously, peripheral zero-wait -> grants alternate 0,1,0,1; each transfer takes 3 cycles; s_owner matches each pulsed ready.
3. Timeout: TIMEOUT=8; m1 write addr=0x0600_0000 and s_ready never asserted -> s_valid high exactly 8 cycles; m1_ready with m1_rdata=0xDEAD_BEEF; timeout_pulse for 1 cycle; err_count=1.
4. Coincident events: s_ready asserted in the cycle wdog==TIMEOUT-1 -> normal completion with peripheral data; timeout_pulse=0; err_count unchanged.
5. Reset mid-transfer: assert reset during BUSY -> next cycle s_valid=0, state IDLE, err_count=0; after release, m0 wins a simultaneous request.
6. Saturation: force 260 timeouts -> err_count stays at 255; timeout_pulse still fires on each one.
